// File: rtl/sim_pcie_axis_traffic_gen_if.sv
// AXI-Stream bundle shared by the PCIe user-side RX source and TX sink.
// master drives the beat, slave drives tready; tuser only flows on RX.
interface sim_pcie_axis_traffic_gen_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;
  logic [21:0]             tuser;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/sim_pcie_axis_traffic_gen.sv
// Simulation stand-in for a PCIe endpoint user interface: RX pattern
// generator with per-function lengths, TX pattern/length checking sink.
module sim_pcie_axis_traffic_gen #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_FUNCS      = 2,
  parameter int LINKUP_TIMEOUT = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TX_THROTTLE    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    user_lnk_up,
  input  logic [2:0]              cfg_function_number,
  input  logic [NUM_FUNCS*16-1:0] func_len_dw,
  input  logic                    rx_enable,
  sim_pcie_axis_traffic_gen_if.master m_axis_rx,
  sim_pcie_axis_traffic_gen_if.slave  s_axis_tx,
  output logic [15:0]             rx_pkt_count,
  output logic [15:0]             tx_pkt_count,
  output logic [31:0]             tx_beat_count,
  output logic                    tx_err
);

  localparam int W  = DATA_WIDTH / 32;
  localparam int KW = DATA_WIDTH / 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
  } beat_t;

  typedef enum logic [1:0] {
    LINK_WAIT,
    IDLE,
    SEND,
    GAP
  } rx_state_t;

  // Lanes past the remaining DWORD count are blanked on the final beat.
  function automatic beat_t mk_beat(
    input logic [31:0] base,
    input logic [15:0] rem
  );
    beat_t b;
    b = '0;
    for (int i = 0; i < W; i++) begin
      if (rem > 16'(i)) begin
        b.data[32*i +: 32] = base + 32'(i);
        b.keep[4*i +: 4]   = 4'hF;
      end
    end
    b.last = (rem <= 16'(W));
    return b;
  endfunction

  logic [31:0] lnk_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lnk_cnt     <= '0;
      user_lnk_up <= 1'b0;
    end else if (lnk_cnt != 32'(LINKUP_TIMEOUT)) begin
      lnk_cnt <= lnk_cnt + 32'd1;
    end else begin
      user_lnk_up <= 1'b1;
    end
  end

  logic [15:0] cfg_len;

  always_comb begin
    cfg_len = '0;
    for (int f = 0; f < NUM_FUNCS; f++) begin
      if (cfg_function_number == 3'(f)) begin
        cfg_len = func_len_dw[16*f +: 16];
      end
    end
  end

  rx_state_t   rx_state;
  logic [31:0] rx_dw;
  logic [15:0] rx_rem;
  logic [7:0]  gap_cnt;
  logic        rx_fire;
  logic [15:0] rx_take;
  beat_t       nxt_first;
  beat_t       nxt_cont;

  assign rx_fire   = m_axis_rx.tvalid && m_axis_rx.tready;
  assign rx_take   = (rx_rem < 16'(W)) ? rx_rem : 16'(W);
  assign nxt_first = mk_beat(rx_dw, cfg_len);
  assign nxt_cont  = mk_beat(rx_dw + 32'(W), rx_rem - 16'(W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state         <= LINK_WAIT;
      rx_dw            <= '0;
      rx_rem           <= '0;
      gap_cnt          <= '0;
      rx_pkt_count     <= '0;
      m_axis_rx.tvalid <= 1'b0;
      m_axis_rx.tdata  <= '0;
      m_axis_rx.tkeep  <= '0;
      m_axis_rx.tlast  <= 1'b0;
      m_axis_rx.tuser  <= '0;
    end else begin
      unique case (rx_state)
        LINK_WAIT: begin
          if (user_lnk_up) rx_state <= IDLE;
        end
        IDLE: begin
          if (rx_enable && cfg_len != 16'd0) begin
            rx_state         <= SEND;
            rx_rem           <= cfg_len;
            m_axis_rx.tvalid <= 1'b1;
            {m_axis_rx.tdata,
             m_axis_rx.tkeep,
             m_axis_rx.tlast} <= nxt_first;
            m_axis_rx.tuser  <= 22'd1 <<
              (22'(cfg_function_number) + 22'd2);
          end
        end
        SEND: begin
          if (rx_fire) begin
            rx_dw <= rx_dw + 32'(rx_take);
            if (m_axis_rx.tlast) begin
              m_axis_rx.tvalid <= 1'b0;
              m_axis_rx.tdata  <= '0;
              m_axis_rx.tkeep  <= '0;
              m_axis_rx.tlast  <= 1'b0;
              m_axis_rx.tuser  <= '0;
              rx_pkt_count     <= rx_pkt_count + 16'd1;
              gap_cnt          <= '0;
              rx_state <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
              rx_rem <= rx_rem - 16'(W);
              {m_axis_rx.tdata,
               m_axis_rx.tkeep,
               m_axis_rx.tlast} <= nxt_cont;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) rx_state <= IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: rx_state <= LINK_WAIT;
      endcase
    end
  end

  logic        tx_fire;
  logic [15:0] tx_n;
  logic        tx_bad;
  logic [31:0] tx_dw;
  logic [16:0] tx_acc;
  logic [16:0] tx_total;
  logic [15:0] tx_len_q;
  logic [15:0] tx_exp_len;
  logic        tx_in_pkt;
  logic [15:0] thr_cnt;

  assign tx_fire    = s_axis_tx.tvalid && s_axis_tx.tready;
  assign tx_exp_len = tx_in_pkt ? tx_len_q : cfg_len;
  assign tx_total   = tx_acc + {1'b0, tx_n};

  // Lane index, not packed position, selects the expected value.
  always_comb begin
    tx_n   = '0;
    tx_bad = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (|s_axis_tx.tkeep[4*i +: 4]) begin
        tx_n = tx_n + 16'd1;
        if (s_axis_tx.tdata[32*i +: 32] != tx_dw + 32'(i))
          tx_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_axis_tx.tready <= 1'b0;
      tx_dw            <= '0;
      tx_acc           <= '0;
      tx_len_q         <= '0;
      tx_in_pkt        <= 1'b0;
      thr_cnt          <= '0;
      tx_beat_count    <= '0;
      tx_pkt_count     <= '0;
      tx_err           <= 1'b0;
    end else begin
      s_axis_tx.tready <= user_lnk_up;
      if (tx_fire) begin
        tx_beat_count <= tx_beat_count + 32'd1;
        tx_dw         <= tx_dw + 32'(tx_n);
        if (tx_bad) tx_err <= 1'b1;
        if (s_axis_tx.tlast) begin
          tx_pkt_count <= tx_pkt_count + 16'd1;
          tx_in_pkt    <= 1'b0;
          tx_acc       <= '0;
          if (tx_total != {1'b0, tx_exp_len}) tx_err <= 1'b1;
        end else begin
          tx_in_pkt <= 1'b1;
          tx_acc    <= tx_total;
          tx_len_q  <= tx_exp_len;
        end
        if (TX_THROTTLE != 0) begin
          if (thr_cnt == 16'(TX_THROTTLE - 1)) begin
            thr_cnt          <= '0;
            s_axis_tx.tready <= 1'b0;
          end else begin
            thr_cnt <= thr_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sim_pcie_axis_traffic_gen.sv
// Bench for sim_pcie_axis_traffic_gen: three widths against a
// packet-level model of the RX pattern and TX sink rules.
module tb_sim_pcie_axis_traffic_gen;
  localparam int LT  = 16;
  localparam int G32 = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        lnk32, en32, err32;
  logic [2:0]  cfg32;
  logic [31:0] len32;
  logic [15:0] rxc32, txc32;
  logic [31:0] txb32;
  logic        lnkw, enw, errw;
  logic [2:0]  cfgw;
  logic [31:0] lenw;
  logic [15:0] rxcw, txcw;
  logic [31:0] txbw;
  logic        lnkt, ent, errt;
  logic [2:0]  cfgt;
  logic [31:0] lent;
  logic [15:0] rxct, txct;
  logic [31:0] txbt;

  sim_pcie_axis_traffic_gen_if #(.DATA_WIDTH(32))  rx32 ();
  sim_pcie_axis_traffic_gen_if #(.DATA_WIDTH(32))  tx32 ();
  sim_pcie_axis_traffic_gen_if #(.DATA_WIDTH(128)) rxw ();
  sim_pcie_axis_traffic_gen_if #(.DATA_WIDTH(128)) txw ();
  sim_pcie_axis_traffic_gen_if #(.DATA_WIDTH(64))  rxt ();
  sim_pcie_axis_traffic_gen_if #(.DATA_WIDTH(64))  txt ();

  sim_pcie_axis_traffic_gen #(
    .DATA_WIDTH(32), .NUM_FUNCS(2), .LINKUP_TIMEOUT(LT),
    .GAP_CYCLES(G32), .TX_THROTTLE(0)
  ) u32 (
    .clk(clk), .rst_n(rst_n), .user_lnk_up(lnk32),
    .cfg_function_number(cfg32), .func_len_dw(len32),
    .rx_enable(en32), .m_axis_rx(rx32), .s_axis_tx(tx32),
    .rx_pkt_count(rxc32), .tx_pkt_count(txc32),
    .tx_beat_count(txb32), .tx_err(err32)
  );

  sim_pcie_axis_traffic_gen #(
    .DATA_WIDTH(128), .NUM_FUNCS(2), .LINKUP_TIMEOUT(LT),
    .GAP_CYCLES(0), .TX_THROTTLE(0)
  ) u128 (
    .clk(clk), .rst_n(rst_n), .user_lnk_up(lnkw),
    .cfg_function_number(cfgw), .func_len_dw(lenw),
    .rx_enable(enw), .m_axis_rx(rxw), .s_axis_tx(txw),
    .rx_pkt_count(rxcw), .tx_pkt_count(txcw),
    .tx_beat_count(txbw), .tx_err(errw)
  );

  sim_pcie_axis_traffic_gen #(
    .DATA_WIDTH(64), .NUM_FUNCS(2), .LINKUP_TIMEOUT(LT),
    .GAP_CYCLES(1), .TX_THROTTLE(2)
  ) u64 (
    .clk(clk), .rst_n(rst_n), .user_lnk_up(lnkt),
    .cfg_function_number(cfgt), .func_len_dw(lent),
    .rx_enable(ent), .m_axis_rx(rxt), .s_axis_tx(txt),
    .rx_pkt_count(rxct), .tx_pkt_count(txct),
    .tx_beat_count(txbt), .tx_err(errt)
  );

  logic [31:0] m32_dw, mw_dw, tx_dw_m;
  int          m32_pkt, tx_acc_m, tx_pkt_m;
  logic        drop_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m32_dw = 0; m32_pkt = 0; mw_dw = 0;
    tx_dw_m = 0; tx_acc_m = 0; tx_pkt_m = 0;
    drop_m = 1'b0;
  endtask

  task automatic idle_inputs();
    en32 = 0; enw = 0; ent = 0;
    cfg32 = 0; cfgw = 0; cfgt = 0;
    len32 = 0; lenw = 0; lent = 0;
    rx32.tready = 0; rxw.tready = 0; rxt.tready = 0;
    tx32.tvalid = 0; tx32.tdata = 0; tx32.tkeep = 0;
    tx32.tlast = 0; tx32.tuser = 0;
    txw.tvalid = 0; txw.tdata = 0; txw.tkeep = 0;
    txw.tlast = 0; txw.tuser = 0;
    txt.tvalid = 0; txt.tdata = 0; txt.tkeep = 0;
    txt.tlast = 0; txt.tuser = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    repeat (LT + 3) tick();
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    len32 = {16'd0, 16'd4}; en32 = 1; rx32.tready = 1;
    rst_n = 0;
    tick(); tick();
    checks++;
    if ({lnk32, rx32.tvalid, rx32.tdata, rx32.tkeep, rx32.tlast,
         rx32.tuser, tx32.tready, rxc32, txc32, txb32, err32} !== '0)
      $display("FAIL reset_u32: outputs not all zero");
    if ({lnk32, rx32.tvalid, rx32.tdata, rx32.tkeep, rx32.tlast,
         rx32.tuser, tx32.tready, rxc32, txc32, txb32, err32} !== '0)
      errors++;
    checks++;
    if ({lnkw, rxw.tvalid, rxw.tdata, rxw.tkeep, rxw.tlast, rxw.tuser,
         txw.tready, rxcw, txcw, txbw, errw} !== '0) begin
      errors++;
      $display("FAIL reset_u128: outputs not all zero");
    end
    checks++;
    if ({lnkt, rxt.tvalid, rxt.tdata, rxt.tkeep, rxt.tlast, rxt.tuser,
         txt.tready, rxct, txct, txbt, errt} !== '0) begin
      errors++;
      $display("FAIL reset_u64: outputs not all zero");
    end
    rst_n = 1;
    repeat (LT) tick();
    checks++;
    if (lnk32 !== 1'b0) begin
      errors++;
      $display("FAIL lnk_early: got %b want 0", lnk32);
    end
    tick();
    checks++;
    if ({lnk32, lnkw, lnkt} !== 3'b111) begin
      errors++;
      $display("FAIL lnk_up: got %b want 111", {lnk32, lnkw, lnkt});
    end
    checks++;
    if (rx32.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL lat0: tvalid %b want 0", rx32.tvalid);
    end
    tick();
    checks++;
    if (rx32.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL lat1: tvalid %b want 0", rx32.tvalid);
    end
    en32 = 0;
    tick(); tick();
    model_clear();
  endtask

  task automatic rx32_run(input int npk, input int rdy_pct,
                          input int len, input int f, input bit vary);
    int got, cyc, gap, lcur, pos, cur_len;
    logic open_p, stall, cntchk, rdy, lst;
    logic [31:0] sd;
    logic [21:0] su;
    got = 0; cyc = 0; gap = 0; lcur = 0; pos = 0; cur_len = len;
    open_p = 0; stall = 0; cntchk = 0; sd = 0; su = 0; lst = 0;
    len32 = '0;
    len32[16*f +: 16] = len[15:0];
    cfg32 = f[2:0];
    en32 = 1;
    while (got < npk && cyc < 3000) begin
      cyc++;
      if (cntchk) begin
        cntchk = 0;
        checks++;
        if (rxc32 !== 16'(m32_pkt)) begin
          errors++;
          $display("FAIL rx32_count: got %0d want %0d", rxc32, m32_pkt);
        end
      end
      if (stall) begin
        checks++;
        if ({rx32.tvalid, rx32.tdata, rx32.tlast, rx32.tuser}
            !== {1'b1, sd, lst, su}) begin
          errors++;
          $display("FAIL rx32_hold: data %h want %h", rx32.tdata, sd);
        end
      end
      if (rx32.tvalid && !open_p) begin
        open_p = 1; pos = 0; lcur = cur_len;
        if (got > 0) begin
          checks++;
          if (gap < G32) begin
            errors++;
            $display("FAIL rx32_gap: got %0d want >=%0d", gap, G32);
          end
        end
        if (vary) begin
          cur_len = $urandom_range(8, 1);
          len32[16*f +: 16] = cur_len[15:0];
        end
      end
      rdy = ($urandom_range(99, 0) < rdy_pct);
      rx32.tready = rdy;
      stall = rx32.tvalid && !rdy;
      sd = rx32.tdata; lst = rx32.tlast; su = rx32.tuser;
      if (rx32.tvalid && rdy) begin
        checks++;
        if ({rx32.tdata, rx32.tkeep, rx32.tlast, rx32.tuser} !==
            {m32_dw, 4'hF, (pos + 1 == lcur), 22'(1) << (2 + f)}) begin
          errors++;
          $display("FAIL rx32_beat: data %h last %b want %h %b",
                   rx32.tdata, rx32.tlast, m32_dw, (pos + 1 == lcur));
        end
        m32_dw++; pos++;
        if (pos == lcur) begin
          got++; m32_pkt++; open_p = 0; cntchk = 1; gap = 0;
          if (got == npk) en32 = 0;
        end
      end else if (!rx32.tvalid) begin
        gap++;
      end
      tick();
    end
    checks++;
    if (got < npk) begin
      errors++;
      $display("FAIL rx32_timeout: got %0d want %0d pkts", got, npk);
    end
    if (cntchk) begin
      checks++;
      if (rxc32 !== 16'(m32_pkt)) begin
        errors++;
        $display("FAIL rx32_count: got %0d want %0d", rxc32, m32_pkt);
      end
    end
    rx32.tready = 0;
  endtask

  task automatic test_rx_basic();
    rx32_run(2, 100, 4, 0, 1'b0);
  endtask

  task automatic test_rx_backpressure();
    rx32_run(8, 50, 5, 1, 1'b1);
  endtask

  task automatic test_rx_len_zero();
    int seen;
    seen = 0;
    len32 = 0; cfg32 = 0; en32 = 1; rx32.tready = 1;
    repeat (40) begin
      tick();
      if (rx32.tvalid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL len_zero: %0d valid cycles want 0", seen);
    end
    seen = 0;
    len32 = {16'd3, 16'd3}; cfg32 = 3'd5;
    repeat (40) begin
      tick();
      if (rx32.tvalid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL bad_func: %0d valid cycles want 0", seen);
    end
    en32 = 0; cfg32 = 0; rx32.tready = 0;
    tick();
  endtask

  task automatic test_rx_wide();
    int got, cyc, pos, lcur, cur_len, idx;
    logic [127:0] ed;
    logic [15:0]  ek;
    logic         el, after_last;
    got = 0; cyc = 0; pos = 0; lcur = 0; cur_len = 6; after_last = 0;
    lenw = {16'd6, 16'd0}; cfgw = 3'd1; enw = 1; rxw.tready = 1;
    while (got < 4 && cyc < 400) begin
      cyc++;
      if (after_last) begin
        after_last = 0;
        checks++;
        if (rxw.tvalid !== 1'b0) begin
          errors++;
          $display("FAIL w_gap: tvalid %b want 0", rxw.tvalid);
        end
      end
      if (rxw.tvalid) begin
        if (pos == 0) lcur = cur_len;
        ed = '0; ek = '0;
        for (int i = 0; i < 4; i++) begin
          idx = pos * 4 + i;
          if (idx < lcur) begin
            ed[32*i +: 32] = mw_dw + 32'(idx);
            ek[4*i +: 4] = 4'hF;
          end
        end
        el = ((pos + 1) * 4 >= lcur);
        checks++;
        if ({rxw.tdata, rxw.tkeep, rxw.tlast, rxw.tuser} !==
            {ed, ek, el, 22'h8}) begin
          errors++;
          $display("FAIL w_beat: %h %h %b want %h %h %b", rxw.tdata,
                   rxw.tkeep, rxw.tlast, ed, ek, el);
        end
        if (got == 0 && pos == 1) begin
          checks++;
          if ({rxw.tdata, rxw.tkeep} !==
              {128'h0000_0000_0000_0000_0000_0005_0000_0004,
               16'h00FF}) begin
            errors++;
            $display("FAIL w_tail: %h %h", rxw.tdata, rxw.tkeep);
          end
        end
        pos++;
        if (el) begin
          mw_dw = mw_dw + 32'(lcur);
          got++; pos = 0; after_last = 1;
          cur_len = $urandom_range(13, 1);
          lenw[31:16] = cur_len[15:0];
          if (got == 4) enw = 0;
        end
      end
      tick();
    end
    checks++;
    if (got < 4 || rxcw !== 16'd4) begin
      errors++;
      $display("FAIL w_count: pkts %0d cnt %0d want 4", got, rxcw);
    end
    rxw.tready = 0;
  endtask

  task automatic tx64_pkt(input int len, input int short_by,
                          input bit bad, input int vpct, input int f);
    int n, nb, j, cyc;
    logic v, two;
    logic [31:0] l0, l1;
    n = len - short_by; nb = (n + 1) / 2; j = 0; cyc = 0;
    cfgt = f[2:0];
    lent[16*f +: 16] = len[15:0];
    while (j < nb && cyc < 500) begin
      cyc++;
      checks++;
      if (txt.tready !== !drop_m) begin
        errors++;
        $display("FAIL tx_ready: got %b want %b", txt.tready, !drop_m);
      end
      l0 = tx_dw_m + 32'(2 * j);
      if (bad && j == 0) l0 = l0 + 32'd7;
      two = (2 * j + 1 < n);
      l1 = two ? tx_dw_m + 32'(2 * j + 1) : $urandom;
      v = ($urandom_range(99, 0) < vpct);
      txt.tvalid = v;
      txt.tdata = {l1, l0};
      txt.tkeep = two ? 8'hFF : 8'h0F;
      txt.tlast = (j == nb - 1);
      drop_m = 0;
      if (v && txt.tready) begin
        j++; tx_acc_m++;
        drop_m = (tx_acc_m % 2 == 0);
      end
      tick();
    end
    txt.tvalid = 0; txt.tlast = 0;
    tx_dw_m = tx_dw_m + 32'(n);
    tx_pkt_m++;
    if (j < nb) begin
      checks++; errors++;
      $display("FAIL tx_timeout: sent %0d of %0d beats", j, nb);
    end
  endtask

  task automatic test_tx_throttle();
    tx64_pkt(6, 0, 1'b0, 100, 0);
    checks++;
    if ({txbt, txct, errt} !== {32'd3, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL tx_first: beats %0d pkts %0d err %b want 3 1 0",
               txbt, txct, errt);
    end
  endtask

  task automatic test_tx_random();
    for (int k = 0; k < 10; k++)
      tx64_pkt($urandom_range(20, 1), 0, 1'b0, 70, $urandom_range(1, 0));
    checks++;
    if ({txbt, txct, errt} !==
        {32'(tx_acc_m), 16'(tx_pkt_m), 1'b0}) begin
      errors++;
      $display("FAIL tx_rand: beats %0d pkts %0d err %b want %0d %0d 0",
               txbt, txct, errt, tx_acc_m, tx_pkt_m);
    end
  endtask

  task automatic test_tx_errors();
    do_reset();
    tx64_pkt(6, 1, 1'b0, 100, 0);
    checks++;
    if (errt !== 1'b1) begin
      errors++;
      $display("FAIL tx_short: err %b want 1", errt);
    end
    tx64_pkt(4, 0, 1'b0, 80, 1);
    tx64_pkt(5, 0, 1'b0, 80, 0);
    checks++;
    if ({errt, txct} !== {1'b1, 16'd3}) begin
      errors++;
      $display("FAIL tx_sticky: err %b pkts %0d want 1 3", errt, txct);
    end
    do_reset();
    tx64_pkt(4, 0, 1'b1, 100, 0);
    checks++;
    if (errt !== 1'b1) begin
      errors++;
      $display("FAIL tx_data: err %b want 1", errt);
    end
    do_reset();
    tx64_pkt(3, 0, 1'b0, 60, 1);
    checks++;
    if (errt !== 1'b0) begin
      errors++;
      $display("FAIL tx_clean: err %b want 0", errt);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    cyc = 0; seen = 0;
    len32 = {16'd0, 16'd16}; cfg32 = 0; en32 = 1; rx32.tready = 1;
    while (seen < 6 && cyc < 200) begin
      cyc++;
      if (rx32.tvalid) seen++;
      tick();
    end
    checks++;
    if (seen < 6) begin
      errors++;
      $display("FAIL mid_start: %0d beats want 6", seen);
    end
    rst_n = 0; en32 = 0; rx32.tready = 0;
    tick();
    checks++;
    if ({rx32.tvalid, lnk32, rxc32, txbt, txct} !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid %b lnk %b cnt %0d want 0",
               rx32.tvalid, lnk32, rxc32);
    end
    tick();
    rst_n = 1;
    repeat (LT) tick();
    checks++;
    if (lnk32 !== 1'b0) begin
      errors++;
      $display("FAIL mid_lnk_early: got %b want 0", lnk32);
    end
    tick();
    checks++;
    if (lnk32 !== 1'b1) begin
      errors++;
      $display("FAIL mid_lnk: got %b want 1", lnk32);
    end
    model_clear();
    rx32_run(1, 100, 4, 0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    model_clear();
    test_reset();
    test_rx_basic();
    test_rx_backpressure();
    test_rx_len_zero();
    test_rx_wide();
    test_tx_throttle();
    test_tx_random();
    test_tx_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sim_pcie_axis_traffic_gen.md
Name: sim_pcie_axis_traffic_gen

Overview:
- Parametrised simulation model of the PCIe endpoint user-side AXI-Stream interface. Used to exercise HDL cores without a hard PCIe block.
- Generates RX (host-to-core) packets with a deterministic incrementing pattern and per-function lengths.
- Sinks TX (core-to-host) packets, checking length and pattern and counting traffic.
- Adds data-width generalisation, true AXI backpressure hold, inter-packet gaps and TX throttling.

Parameters:
- DATA_WIDTH, 32, stream data width in bits; legal values 32, 64, 128.
- NUM_FUNCS, 2, number of PCIe functions, 1..8.
- LINKUP_TIMEOUT, 16, clk cycles after reset release before user_lnk_up asserts.
- GAP_CYCLES, 2, idle cycles between RX packets, 0..255.
- TX_THROTTLE, 0, TX tready deasserted for 1 cycle after every TX_THROTTLE accepted beats; 0 means always ready.

Ports:
- clk  in  1  user clock
- rst_n  in  1  synchronous active-low reset
- user_lnk_up  out  1  link-up indication
- cfg_function_number  in  3  selects active function (values >= NUM_FUNCS treated as length 0)
- func_len_dw  in  NUM_FUNCS*16  per-function packet length in DWORDs; function f at bits [16f+15:16f]
- rx_enable  in  1  permits RX packet generation
- m_axis_rx_tdata  out  DATA_WIDTH  RX data
- m_axis_rx_tkeep  out  DATA_WIDTH/8  byte enables
- m_axis_rx_tlast  out  1  last beat
- m_axis_rx_tvalid  out  1  valid
- m_axis_rx_tready  in  1  ready
- m_axis_rx_tuser  out  22  bits[9:2] one-hot BAR/function hit; other bits 0
- s_axis_tx_tdata  in  DATA_WIDTH  TX data
- s_axis_tx_tkeep  in  DATA_WIDTH/8  byte enables
- s_axis_tx_tlast  in  1  last beat
- s_axis_tx_tvalid  in  1  valid
- s_axis_tx_tready  out  1  ready
- rx_pkt_count  out  16  RX packets completed
- tx_pkt_count  out  16  TX packets accepted
- tx_beat_count  out  32  TX beats accepted
- tx_err  out  1  sticky TX error flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0.
  - Pattern counters go to 0. RX FSM enters LINK_WAIT.
  - Reset mid-packet abandons the packet immediately; the next tvalid is 0.
- Link-up:
  - A counter increments from reset release.
  - user_lnk_up=1 on the cycle after it reaches LINKUP_TIMEOUT. It then holds until reset.
- Sizing: W = DATA_WIDTH/32 DWORDs per beat. Beats per packet = ceil(len/W), with len latched at packet start.
- RX FSM:
  - LINK_WAIT -> IDLE when user_lnk_up=1.
  - IDLE -> SEND when rx_enable=1 and latched len != 0. If len == 0, stay in IDLE with no output.
  - SEND: tvalid=1. Advance to the next beat only on tvalid && tready. While tready=0, tdata, tkeep, tlast and tuser hold stable.
  - SEND -> GAP on the accepted beat with tlast=1. rx_pkt_count increments, wrapping at 16 bits.
  - GAP: waits GAP_CYCLES cycles, then -> IDLE. If GAP_CYCLES=0, go straight to IDLE; next tvalid is no sooner than 1 cycle after tlast acceptance.
  - Function number and len are latched at IDLE -> SEND. Changes mid-packet are ignored.
- RX data:
  - Lane i (bits 32i+31:32i) = rx_dw_counter + i.
  - rx_dw_counter is a 32-bit counter. It advances by the number of valid DWORDs on each accepted beat and persists across packets (wraps mod 2^32).
  - On the last beat, lanes at index >= remaining DWORDs are zero and their tkeep nibbles are 0. All other tkeep bits are 1.
  - tlast is asserted only on the final beat.
  - tuser[2+f]=1 for latched function f throughout the packet.
- TX sink:
  - s_axis_tx_tready=1 after link-up, except one deassert cycle following every TX_THROTTLE-th accepted beat.
  - tx_beat_count increments on each accepted beat; on tlast, tx_pkt_count increments.
  - Expected pattern: each keep-enabled lane must equal tx_dw_counter + lane index, where tx_dw_counter is an independent 32-bit counter advanced by valid DWORDs.
  - Expected length: the count of accepted DWORDs up to tlast must equal func_len_dw of cfg_function_number sampled at the packet's first beat.
  - Any mismatch sets tx_err=1, sticky until reset. Accepting a beat before link-up is impossible because tready=0.
  - TX and RX operate fully concurrently and independently.
- Latency: first RX tvalid no earlier than 2 cycles after user_lnk_up rises.

Test Plan:
- DATA_WIDTH=32, len0=4, func=0, tready=1 -> 4 beats with tdata 0,1,2,3, tlast on beat 4, tuser[2]=1, rx_pkt_count=1. Next packet starts with tdata=4 after GAP_CYCLES.
- DATA_WIDTH=128, len1=6, func=1 -> beat 1 = {3,2,1,0} with tkeep=16'hFFFF; beat 2 = {0,0,5,4} with tkeep=16'h00FF and tlast=1; tuser[3]=1.
- RX backpressure: tready toggles 1,0,0,1 mid-packet -> tdata/tkeep/tlast remain stable while stalled, and no DWORD is skipped or repeated.
- TX, DATA_WIDTH=64, TX_THROTTLE=2: core sends 3 beats {1,0},{3,2},{5,4} with len=6 -> tready drops for 1 cycle after the 2nd beat; tx_beat_count=3, tx_pkt_count=1, tx_err=0.
- TX error cases, each on a fresh reset: tlast after 5 DWORDs with len=6 -> tx_err=1, and it stays 1 through subsequent good packets. Wrong data value on lane 0 -> tx_err=1.
- rst_n=0 in the middle of a 16-beat RX packet -> next cycle tvalid=0, counts=0, user_lnk_up=0. After release, link-up arrives after LINKUP_TIMEOUT cycles and the pattern restarts at 0. len=0 -> no tvalid ever.
